// File: rtl/updown_dir_ctrl.sv
// -----------------------------------------------------------------------------
// updown_dir_ctrl
//
// Direction controller for an up/down counter stage on the same clock.
// A debounced pushbutton toggles the count direction. With auto_mode set, the
// block also watches the counter's count value and reverses direction one step
// before each range end. The counter and the direction register move on the
// same edge, so the counter reaches the end value and then turns around
// without wrapping: 0,1,2,3,2,1,0,... for N=2.
//
// Parameters
//   N          width of the counter's count bus (N >= 2)
//   DB_CYCLES  consecutive cycles the synchronized button must differ from its
//              debounced value before that value updates (DB_CYCLES >= 2)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset; overrides every other input
//   btn         raw pushbutton, asynchronous to clk, may bounce
//   auto_mode   1 = ping-pong reversal at the range ends is enabled
//   count       feedback from the counter's count output
//   up_or_down  registered direction: 1 = up, 0 = down (reset value 1)
//   btn_pulse   registered one-cycle pulse per debounced press (0->1 only)
//   reversal    registered one-cycle pulse in the first cycle a new
//               up_or_down value is presented
// -----------------------------------------------------------------------------
module updown_dir_ctrl #(
    parameter int N         = 2,
    parameter int DB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn,
    input  logic         auto_mode,
    input  logic [N-1:0] count,
    output logic         up_or_down,
    output logic         btn_pulse,
    output logic         reversal
);

    localparam int CW = $clog2(DB_CYCLES) + 1;

    localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
    // One step short of each end: the counter steps on the edge the direction
    // flips, so these values land it exactly on 2^N-1 or 0.
    localparam logic [N-1:0]  UP_TURN   = {{(N-1){1'b1}}, 1'b0};
    localparam logic [N-1:0]  DOWN_TURN = N'(1);

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Two-flop synchronizer on the raw button
    logic          sync1_q;
    logic          sync2_q;

    // Debouncer
    logic          db_state_q, db_state_d;
    logic [CW-1:0] db_cnt_q,   db_cnt_d;
    logic          db_prev_q;

    // Registered outputs and direction state
    logic          btn_pulse_q, btn_pulse_d;
    dir_e          dir_q,       dir_d;
    logic          reversal_q,  reversal_d;

    logic          auto_hit;

    // NOTE: every signal assigned here gets a default at the top of the block,
    // so no path can leave one unassigned and infer a latch.
    always_comb begin
        db_state_d  = db_state_q;
        db_cnt_d    = '0;
        btn_pulse_d = 1'b0;
        dir_d       = dir_q;
        reversal_d  = 1'b0;
        auto_hit    = 1'b0;

        // Debounce: the synchronized button must disagree with the debounced
        // value for DB_CYCLES consecutive edges; any agreement restarts it.
        if (sync2_q != db_state_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_state_d = sync2_q;
                db_cnt_d   = '0;
            end else begin
                db_cnt_d   = db_cnt_q + CW'(1);
            end
        end

        // Rising edge of the debounced state only; a release never pulses.
        btn_pulse_d = db_state_q & ~db_prev_q;

        // Compare against the pre-edge count value.
        auto_hit = auto_mode &
                   (((dir_q == DIR_UP)   && (count == UP_TURN)) ||
                    ((dir_q == DIR_DOWN) && (count == DOWN_TURN)));

        // A press and an end-point hit in the same cycle give a single toggle.
        if (btn_pulse_q || auto_hit) begin
            dir_d = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
        end

        reversal_d = btn_pulse_q | auto_hit;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            db_state_q  <= 1'b0;
            db_cnt_q    <= '0;
            db_prev_q   <= 1'b0;
            btn_pulse_q <= 1'b0;
            dir_q       <= DIR_UP;
            reversal_q  <= 1'b0;
        end else begin
            sync1_q     <= btn;
            sync2_q     <= sync1_q;
            db_state_q  <= db_state_d;
            db_cnt_q    <= db_cnt_d;
            db_prev_q   <= db_state_q;
            btn_pulse_q <= btn_pulse_d;
            dir_q       <= dir_d;
            reversal_q  <= reversal_d;
        end
    end

    assign up_or_down = (dir_q == DIR_UP);
    assign btn_pulse  = btn_pulse_q;
    assign reversal   = reversal_q;

endmodule
